rr_merge: RTL
=============

// Module: rr_merge
// PURPOSE
// - Round-robin arbiter/merge: shares one native-bus slave port among N_MASTERS masters.
// - Counterpart of the address-decoding splitter; sits between CPU/DMA masters and a shared memory or peripheral bus.
// - One transaction in flight; the granted master's request is routed to the slave until the slave returns ready.
// - The rdata/ready response goes back to the granted master only.
// PARAMETERS
// - DATA_W     32  data width; REQ_W/RESP_W come from the shared header.
// - ADDR_W     32  address width.
// - N_MASTERS  2   number of requesters, >=2; MW = $clog2(N_MASTERS).
// PORTS
// - clk     in   1                    system clock; all state updates on rising edge.
// - rst     in   1                    synchronous, active-high reset.
// - m_req   in   N_MASTERS*REQ_W      master requests; slice i = {valid, addr, wdata, wstrb}, valid = MSB.
// - m_resp  out  N_MASTERS*RESP_W     master responses; slice i = {rdata, ready}, ready = LSB.
// - s_req   out  REQ_W                request to the shared slave.
// - s_resp  in   RESP_W               response from the shared slave.
// - grant   out  MW                   index of the current/last granted master (debug/profiling).
// - busy    out  1                    1 while a transaction is in flight.
// BEHAVIOUR
// - States: IDLE, BUSY; 1-bit state register; also registers grant and prio (MW bits each).
// - Reset: state=IDLE, grant=0, prio=0, busy=0.
//   - s_req and all m_resp slices are 0 while in reset and in IDLE.
//   - Reset mid-transaction: drops the transaction; the slave sees valid low on the next cycle.
// - IDLE, no master valid: hold state, grant and prio.
// - IDLE, any master valid: grant = first valid index scanning prio, prio+1, ... with wrap at N_MASTERS-1 -> 0.
//   - Registered: grant updates and state -> BUSY at the next edge.
//   - Arbitration costs exactly 1 cycle.
// - BUSY:
//   - s_req = m_req[grant] combinationally.
//   - m_resp[grant] = s_resp; all other m_resp slices = 0.
//   - The slave may assert ready in the first BUSY cycle or any later cycle.
// - BUSY and s_resp.ready=1:
//   - Next state IDLE.
//   - prio <= grant+1, wrapping to 0 after N_MASTERS-1.
// - Master rule: hold valid and the request fields stable until ready; drop valid the cycle after ready.
// - Throughput: at most one transaction per 2 cycles (IDLE gap between grants).
//   - With two masters continuously valid, grants alternate 0,1,0,1.
// - Simultaneous requests: resolved purely by prio; the master just served has lowest priority next round.
// - Granted master drops valid in BUSY (protocol violation): the arbiter stays BUSY until ready; no timeout.
// - Non-granted masters asserting valid during BUSY: ignored and held off until a later IDLE.
// - Width rule: grant/prio increment is mod N_MASTERS, including non-power-of-2 N_MASTERS.
//   - Indices >= N_MASTERS are never produced.
// STRUCTURE
// - Shared header interconnect.vh provides:
//   - REQ_W, RESP_W, VALID/ADDR/WDATA/WSTRB/RDATA/READY field positions.
//   - req(i)/resp(i) slice macros.
//   - No new local constants.
// - Sub-module rr_pick (combinational, parameter N):
//   - Inputs: req_vec[N-1:0], prio[MW-1:0].
//   - Outputs: any, idx[MW-1:0].
//   - Reused by future multi-port arbiters.
// - Top level: state FSM, grant/prio registers, request/response muxing.
// TESTING
// - Reset: hold rst 3 cycles with m0 and m1 valid -> s_req=0, m_resp=0, busy=0, grant=0; first grant is m0.
// - Single master: m1 write addr 0x10, wdata 0xA5A5A5A5, slave ready 2 cycles later ->
//   - s_req equals m1's request.
//   - m1 sees ready once; m0 resp stays 0.
//   - prio=0 afterwards.
// - Contention: m0 and m1 continuously valid, N_MASTERS=2, slave ready in 1st BUSY cycle ->
//   - grant sequence 0,1,0,1.
//   - One transaction every 2 cycles.
// - Read return: m0 read, slave returns rdata 0xDEADBEEF with ready ->
//   - m0 rdata=0xDEADBEEF.
//   - m1 rdata=0 in the same cycle.
// - N_MASTERS=3, only m0 and m2 valid, prio=1 -> grant 2 first, then 0; never index 3.
// - Reset asserted in BUSY before ready -> next cycle s_req.valid=0, state IDLE, prio=0.

Source files
------------

// File: rtl/rr_merge_pkg.sv
// Shared bus geometry for the round-robin merge: request/response widths,
// field positions, FSM state type and small index/packing helpers.
package rr_merge_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  localparam int REQ_W     = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W    = DATA_W + 1;

  localparam int WSTRB_LSB = 0;
  localparam int WDATA_LSB = STRB_W;
  localparam int ADDR_LSB  = STRB_W + DATA_W;
  localparam int VALID_BIT = REQ_W - 1;
  localparam int READY_BIT = 0;
  localparam int RDATA_LSB = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Increment an index modulo n, so non-power-of-2 counts never overflow.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic logic [REQ_W-1:0] makeReq(input logic              valid,
                                               input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] wdata,
                                               input logic [STRB_W-1:0] wstrb);
    return {valid, addr, wdata, wstrb};
  endfunction

endpackage

// File: rtl/rr_merge_if.sv
// Native bus bundle carrying N request slices and N response slices;
// N=1 describes a single slave port.
interface rr_merge_if #(parameter int N = 1);
  import rr_merge_pkg::*;

  logic [N*REQ_W-1:0]  req;
  logic [N*RESP_W-1:0] resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/rr_merge_pick.sv
// Combinational round-robin picker: first set bit of req_vec scanning
// upward from prio with wrap at N-1.
module rr_pick #(
  parameter int N  = 2,
  parameter int MW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_vec,
  input  logic [MW-1:0] prio,
  output logic          any,
  output logic [MW-1:0] idx
);

  logic [MW:0] w_cand;

  // Scan from the far end back to prio so the closest candidate wins last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = {1'b0, prio} + (MW+1)'(k);
      if (w_cand >= (MW+1)'(N)) begin
        w_cand = w_cand - (MW+1)'(N);
      end
      if (req_vec[w_cand[MW-1:0]]) begin
        any = 1'b1;
        idx = w_cand[MW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_merge.sv
// Round-robin merge: shares one slave port among N_MASTERS masters with one
// transaction in flight and a one-cycle registered arbitration step.
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter  int N_MASTERS = 2,
  localparam int MW        = $clog2(N_MASTERS)
) (
  input  logic          clk,
  input  logic          rst,
  rr_merge_if.slave     m_bus,
  rr_merge_if.master    s_bus,
  output logic [MW-1:0] grant,
  output logic          busy
);

  state_t               r_state;
  state_t               w_stateNext;
  logic [MW-1:0]        r_grant;
  logic [MW-1:0]        r_prio;
  logic [MW-1:0]        w_grantNext;
  logic [MW-1:0]        w_prioNext;
  logic [MW-1:0]        w_pickIdx;
  logic                 w_pickAny;
  logic [N_MASTERS-1:0] w_valid;
  logic                 w_ready;
  logic                 w_active;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
    assign w_valid[i] = m_bus.req[i*REQ_W + VALID_BIT];
  end

  rr_pick #(.N(N_MASTERS), .MW(MW)) u_pick (
    .req_vec (w_valid),
    .prio    (r_prio),
    .any     (w_pickAny),
    .idx     (w_pickIdx)
  );

  assign w_ready  = s_bus.resp[READY_BIT];
  assign w_active = (r_state == ST_BUSY) && !rst;

  always_comb begin
    w_stateNext = r_state;
    w_grantNext = r_grant;
    w_prioNext  = r_prio;
    case (r_state)
      ST_IDLE: begin
        if (w_pickAny) begin
          w_stateNext = ST_BUSY;
          w_grantNext = w_pickIdx;
        end
      end
      ST_BUSY: begin
        // Just-served master drops to lowest priority for the next round.
        if (w_ready) begin
          w_stateNext = ST_IDLE;
          w_prioNext  = MW'(wrapInc(int'(r_grant), N_MASTERS));
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_prio  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_grant <= w_grantNext;
      r_prio  <= w_prioNext;
    end
  end

  // Outputs are gated by rst so an aborted transaction vanishes immediately.
  always_comb begin
    s_bus.req  = '0;
    m_bus.resp = '0;
    if (w_active) begin
      s_bus.req = m_bus.req[int'(r_grant)*REQ_W +: REQ_W];
      m_bus.resp[int'(r_grant)*RESP_W +: RESP_W] = s_bus.resp;
    end
  end

  assign grant = r_grant;
  assign busy  = w_active;

endmodule
